// File: rtl/ni_flit_ejector_pkg.sv
// Shared NoC definitions: flit field positions, flit width and ejector FSM states.
package ni_flit_ejector_pkg;

    typedef enum logic {
        EJ_IDLE   = 1'b0,
        EJ_LOCKED = 1'b1
    } ej_state_e;

    // Flit layout, MSB first: {hdr, tail, vc[V-1:0], payload[Fpay-1:0]}
    function automatic int flit_w(input int v, input int fpay);
        return 2 + v + fpay;
    endfunction

    function automatic int hdr_pos(input int v, input int fpay);
        return 1 + v + fpay;
    endfunction

    function automatic int tail_pos(input int v, input int fpay);
        return v + fpay;
    endfunction

    function automatic int vc_lsb(input int fpay);
        return fpay;
    endfunction

endpackage

// File: rtl/ni_vc_fifo.sv
// Single-VC flit buffer: B entries (B a power of two), registered head, net-zero push+pop.
module ni_vc_fifo #(
    parameter int W = 36,
    parameter int B = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push_i,
    input  logic         pop_i,
    input  logic [W-1:0] din_i,
    output logic         full_o,
    output logic         empty_o,
    output logic [W-1:0] head_o
);
    localparam int AW = $clog2(B);

    logic [W-1:0]  mem [B];
    logic [AW-1:0] wptr_q, rptr_q;
    logic [AW:0]   cnt_q;

    always_ff @(posedge clk) begin
        if (push_i) mem[wptr_q] <= din_i;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            if (push_i) wptr_q <= wptr_q + 1'b1;
            if (pop_i)  rptr_q <= rptr_q + 1'b1;
            case ({push_i, pop_i})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    assign full_o  = (cnt_q == (AW+1)'(B));
    assign empty_o = (cnt_q == '0);
    assign head_o  = mem[rptr_q];

endmodule

// File: rtl/ni_flit_ejector.sv
// Network-interface ejector: per-VC flit buffers, packet-atomic round-robin VC selection,
// credit return per popped flit.
module ni_flit_ejector
    import ni_flit_ejector_pkg::*;
#(
    parameter int V    = 2,
    parameter int B    = 4,
    parameter int Fpay = 32,
    localparam int Fw  = flit_w(V, Fpay)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [Fw-1:0]   flit_in,
    input  logic            flit_in_wr,
    output logic [V-1:0]    credit_out,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [Fpay-1:0] out_payload,
    output logic            out_hdr,
    output logic            out_tail,
    output logic [V-1:0]    out_vc,
    output logic            ovf_err,
    output logic            vc_err
);
    localparam int HB = hdr_pos(V, Fpay);
    localparam int TB = tail_pos(V, Fpay);
    localparam int VL = vc_lsb(Fpay);
    localparam int VW = (V > 1) ? $clog2(V) : 1;

    logic [V-1:0]         push, pop, full, empty;
    logic [V-1:0][Fw-1:0] head;
    logic [V-1:0]         in_vc;
    logic                 in_ok, ovf_hit, vc_bad;

    ej_state_e            state_q, state_d;
    logic [VW-1:0]        lock_q, lock_d, rr_q, rr_d;
    logic [V-1:0]         credit_q;
    logic                 ovf_q, vcerr_q;

    logic [VW-1:0]        sel;
    logic                 sel_vld, fire;
    logic [Fw-1:0]        sel_head;

    assign in_vc   = flit_in[VL+V-1:VL];
    assign in_ok   = flit_in_wr && $onehot(in_vc);
    assign vc_bad  = flit_in_wr && !$onehot(in_vc);
    // A full VC still accepts when its head leaves in the same cycle.
    assign ovf_hit = in_ok && |(in_vc & full & ~pop);

    for (genvar v = 0; v < V; v++) begin : g_vc
        assign push[v] = in_ok && in_vc[v] && (!full[v] || pop[v]);

        ni_vc_fifo #(.W(Fw), .B(B)) u_fifo (
            .clk     (clk),
            .reset   (reset),
            .push_i  (push[v]),
            .pop_i   (pop[v]),
            .din_i   (flit_in),
            .full_o  (full[v]),
            .empty_o (empty[v]),
            .head_o  (head[v])
        );
    end

    always_comb begin
        int idx;
        idx     = 0;
        sel     = lock_q;
        sel_vld = 1'b0;
        if (state_q == EJ_LOCKED) begin
            sel_vld = !empty[lock_q];
        end else begin
            for (int i = 0; i < V; i++) begin
                idx = int'(rr_q) + i;
                if (idx >= V) idx = idx - V;
                if (!sel_vld && !empty[idx] && head[idx][HB]) begin
                    sel_vld = 1'b1;
                    sel     = VW'(idx);
                end
            end
        end
    end

    assign sel_head = head[sel];
    assign fire     = sel_vld && out_ready;
    assign pop      = fire ? (V'(1) << sel) : '0;

    always_comb begin
        state_d = state_q;
        lock_d  = lock_q;
        rr_d    = rr_q;
        if (fire) begin
            case (state_q)
                EJ_IDLE: begin
                    rr_d = (sel == VW'(V-1)) ? '0 : sel + 1'b1;
                    if (sel_head[HB] && !sel_head[TB]) begin
                        state_d = EJ_LOCKED;
                        lock_d  = sel;
                    end
                end
                EJ_LOCKED: if (sel_head[TB]) state_d = EJ_IDLE;
                default:   state_d = EJ_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= EJ_IDLE;
            lock_q   <= '0;
            rr_q     <= '0;
            credit_q <= '0;
            ovf_q    <= 1'b0;
            vcerr_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            lock_q   <= lock_d;
            rr_q     <= rr_d;
            credit_q <= pop;
            ovf_q    <= ovf_q | ovf_hit;
            vcerr_q  <= vcerr_q | vc_bad;
        end
    end

    assign out_valid   = sel_vld;
    assign out_payload = sel_vld ? sel_head[Fpay-1:0]   : '0;
    assign out_hdr     = sel_vld ? sel_head[HB]         : 1'b0;
    assign out_tail    = sel_vld ? sel_head[TB]         : 1'b0;
    assign out_vc      = sel_vld ? sel_head[VL+V-1:VL]  : '0;
    assign credit_out  = credit_q;
    assign ovf_err     = ovf_q;
    assign vc_err      = vcerr_q;

endmodule

// File: tb/tb_ni_flit_ejector.sv
// Directed bench for ni_flit_ejector with V=2, B=4, Fpay=32.
module tb_ni_flit_ejector;
    localparam int V = 2, B = 4, Fpay = 32, Fw = 2 + V + Fpay;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic [Fw-1:0]   flit_in = '0;
    logic            flit_in_wr = 1'b0;
    logic [V-1:0]    credit_out;
    logic            out_valid;
    logic            out_ready = 1'b0;
    logic [Fpay-1:0] out_payload;
    logic            out_hdr, out_tail;
    logic [V-1:0]    out_vc;
    logic            ovf_err, vc_err;

    int n_cmp = 0;
    int n_bad = 0;

    ni_flit_ejector #(.V(V), .B(B), .Fpay(Fpay)) dut (
        .clk(clk), .reset(reset), .flit_in(flit_in), .flit_in_wr(flit_in_wr),
        .credit_out(credit_out), .out_valid(out_valid), .out_ready(out_ready),
        .out_payload(out_payload), .out_hdr(out_hdr), .out_tail(out_tail),
        .out_vc(out_vc), .ovf_err(ovf_err), .vc_err(vc_err)
    );

    always #5 clk = ~clk;

    function automatic logic [Fw-1:0] mk(input logic h, input logic t, input logic [V-1:0] vc,
                                         input logic [Fpay-1:0] p);
        return {h, t, vc, p};
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [Fw-1:0] f);
        flit_in    = f;
        flit_in_wr = 1'b1;
        tick();
        flit_in_wr = 1'b0;
    endtask

    task automatic apply_reset;
        flit_in_wr = 1'b0;
        out_ready  = 1'b0;
        reset      = 1'b1;
        repeat (2) tick();
        reset = 1'b0;
        tick();
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (2) tick();
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL rst_valid got=%b exp=0", out_valid); end
        n_cmp++; if (out_payload !== '0) begin n_bad++; $display("FAIL rst_payload got=%h exp=0", out_payload); end
        n_cmp++; if ({out_hdr, out_tail, out_vc} !== 4'b0) begin n_bad++; $display("FAIL rst_fields got=%b exp=0000", {out_hdr, out_tail, out_vc}); end
        n_cmp++; if (credit_out !== 2'b00) begin n_bad++; $display("FAIL rst_credit got=%b exp=00", credit_out); end
        n_cmp++; if ({ovf_err, vc_err} !== 2'b00) begin n_bad++; $display("FAIL rst_errs got=%b exp=00", {ovf_err, vc_err}); end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_single;
        apply_reset();
        out_ready = 1'b1;
        wr(mk(1'b1, 1'b1, 2'b10, 32'hA5));
        n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL single_valid got=%b exp=1", out_valid); end
        n_cmp++; if (out_vc !== 2'b10) begin n_bad++; $display("FAIL single_vc got=%b exp=10", out_vc); end
        n_cmp++; if (out_payload !== 32'hA5) begin n_bad++; $display("FAIL single_payload got=%h exp=a5", out_payload); end
        n_cmp++; if ({out_hdr, out_tail} !== 2'b11) begin n_bad++; $display("FAIL single_ht got=%b exp=11", {out_hdr, out_tail}); end
        tick();
        n_cmp++; if (credit_out !== 2'b10) begin n_bad++; $display("FAIL single_credit got=%b exp=10", credit_out); end
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL single_drained got=%b exp=0", out_valid); end
        tick();
        n_cmp++; if (credit_out !== 2'b00) begin n_bad++; $display("FAIL single_credit_end got=%b exp=00", credit_out); end
    endtask

    task automatic test_interleave;
        logic [Fpay-1:0] exp [6];
        exp = '{32'h10, 32'h11, 32'h12, 32'h20, 32'h21, 32'h22};
        apply_reset();
        wr(mk(1'b1, 1'b0, 2'b01, 32'h10));
        wr(mk(1'b1, 1'b0, 2'b10, 32'h20));
        wr(mk(1'b0, 1'b0, 2'b01, 32'h11));
        wr(mk(1'b0, 1'b0, 2'b10, 32'h21));
        wr(mk(1'b0, 1'b1, 2'b01, 32'h12));
        wr(mk(1'b0, 1'b1, 2'b10, 32'h22));
        n_cmp++; if (out_payload !== 32'h10) begin n_bad++; $display("FAIL hold_a got=%h exp=10", out_payload); end
        tick();
        n_cmp++; if (out_payload !== 32'h10 || out_valid !== 1'b1) begin n_bad++; $display("FAIL hold_b got=%h/%b exp=10/1", out_payload, out_valid); end
        out_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            n_cmp++;
            if (out_valid !== 1'b1 || out_payload !== exp[k]) begin
                n_bad++; $display("FAIL ilv_%0d got=%b/%h exp=1/%h", k, out_valid, out_payload, exp[k]);
            end
            tick();
        end
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL ilv_empty got=%b exp=0", out_valid); end
    endtask

    task automatic test_overflow;
        int got;
        apply_reset();
        for (int i = 0; i < B + 1; i++) wr(mk(1'b1, 1'b1, 2'b01, 32'h30 + i));
        n_cmp++; if (ovf_err !== 1'b1) begin n_bad++; $display("FAIL ovf_flag got=%b exp=1", ovf_err); end
        out_ready = 1'b1;
        got = 0;
        for (int c = 0; c < 10; c++) begin
            if (out_valid === 1'b1) begin
                n_cmp++;
                if (out_payload !== 32'h30 + got) begin n_bad++; $display("FAIL ovf_data_%0d got=%h exp=%h", got, out_payload, 32'h30 + got); end
                got++;
            end
            tick();
        end
        n_cmp++; if (got != B) begin n_bad++; $display("FAIL ovf_count got=%0d exp=%0d", got, B); end
    endtask

    task automatic test_vc_err;
        apply_reset();
        out_ready = 1'b1;
        wr(mk(1'b1, 1'b1, 2'b11, 32'hBAD));
        n_cmp++; if (vc_err !== 1'b1) begin n_bad++; $display("FAIL vcerr_flag got=%b exp=1", vc_err); end
        n_cmp++; if (ovf_err !== 1'b0) begin n_bad++; $display("FAIL vcerr_ovf got=%b exp=0", ovf_err); end
        for (int c = 0; c < 3; c++) begin
            n_cmp++;
            if (out_valid !== 1'b0 || credit_out !== 2'b00) begin
                n_bad++; $display("FAIL vcerr_quiet_%0d got=%b/%b exp=0/00", c, out_valid, credit_out);
            end
            tick();
        end
    endtask

    task automatic test_full_same_cycle;
        int got;
        apply_reset();
        for (int i = 0; i < B; i++) wr(mk(1'b1, 1'b1, 2'b01, 32'h40 + i));
        n_cmp++; if (out_payload !== 32'h40) begin n_bad++; $display("FAIL sc_head got=%h exp=40", out_payload); end
        out_ready = 1'b1;
        wr(mk(1'b1, 1'b1, 2'b01, 32'h44));
        out_ready = 1'b0;
        n_cmp++; if (ovf_err !== 1'b0) begin n_bad++; $display("FAIL sc_ovf got=%b exp=0", ovf_err); end
        n_cmp++; if (credit_out !== 2'b01) begin n_bad++; $display("FAIL sc_credit got=%b exp=01", credit_out); end
        n_cmp++; if (out_payload !== 32'h41) begin n_bad++; $display("FAIL sc_next got=%h exp=41", out_payload); end
        tick();
        n_cmp++; if (credit_out !== 2'b00) begin n_bad++; $display("FAIL sc_pulse got=%b exp=00", credit_out); end
        out_ready = 1'b1;
        got = 0;
        for (int c = 0; c < 10; c++) begin
            if (out_valid === 1'b1) begin
                n_cmp++;
                if (out_payload !== 32'h41 + got) begin n_bad++; $display("FAIL sc_data_%0d got=%h exp=%h", got, out_payload, 32'h41 + got); end
                got++;
            end
            tick();
        end
        n_cmp++; if (got != B) begin n_bad++; $display("FAIL sc_count got=%0d exp=%0d", got, B); end
    endtask

    task automatic test_reset_mid;
        apply_reset();
        out_ready = 1'b1;
        wr(mk(1'b1, 1'b0, 2'b01, 32'h50));
        wr(mk(1'b0, 1'b0, 2'b01, 32'h51));
        n_cmp++; if (out_payload !== 32'h51) begin n_bad++; $display("FAIL mid_body got=%h exp=51", out_payload); end
        reset = 1'b1;
        #1;
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL mid_valid got=%b exp=0", out_valid); end
        n_cmp++; if (credit_out !== 2'b00) begin n_bad++; $display("FAIL mid_credit got=%b exp=00", credit_out); end
        n_cmp++; if (out_payload !== '0 || out_vc !== '0) begin n_bad++; $display("FAIL mid_fields got=%h/%b exp=0/00", out_payload, out_vc); end
        tick();
        reset = 1'b0;
        tick();
        n_cmp++; if (out_valid !== 1'b0 || credit_out !== 2'b00) begin n_bad++; $display("FAIL mid_after got=%b/%b exp=0/00", out_valid, credit_out); end
        out_ready = 1'b0;
        wr(mk(1'b1, 1'b1, 2'b10, 32'h60));
        n_cmp++;
        if (out_valid !== 1'b1 || out_vc !== 2'b10 || out_payload !== 32'h60) begin
            n_bad++; $display("FAIL mid_idle got=%b/%b/%h exp=1/10/60", out_valid, out_vc, out_payload);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_interleave();
        test_overflow();
        test_vc_err();
        test_full_same_cycle();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/ni_flit_ejector.md
NI_FLIT_EJECTOR -- requirements
Module: ni_flit_ejector

Interface
REQ-001 SHALL have parameter V, default 2: number of virtual channels.
REQ-002 SHALL have parameter B, default 4: flit buffer depth per VC, power of two, at least 2.
REQ-003 SHALL have parameter Fpay, default 32: flit payload width; local constant Fw = 2+V+Fpay.
REQ-004 SHALL have port clk, input, 1: clock.
REQ-005 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-006 SHALL have port flit_in, input, Fw: router flit. Fields: bit Fw-1 header, bit Fw-2 tail, bits [Fpay+V-1:Fpay] one-hot VC, bits [Fpay-1:0] payload.
REQ-007 SHALL have port flit_in_wr, input, 1: flit_in valid this cycle.
REQ-008 SHALL have port credit_out, output, V: per-VC credit return pulse to the router.
REQ-009 SHALL have port out_valid, input-facing output, 1: a flit is presented to the core (direction: output).
REQ-010 SHALL have port out_ready, input, 1: core accepts the presented flit.
REQ-011 SHALL have port out_payload, output, Fpay: payload of the presented flit.
REQ-012 SHALL have ports out_hdr and out_tail, output, 1 each: header and tail bits of the presented flit.
REQ-013 SHALL have port out_vc, output, V: one-hot VC of the presented flit.
REQ-014 SHALL have port ovf_err, output, 1: sticky flag, write to a full VC.
REQ-015 SHALL have port vc_err, output, 1: sticky flag, VC field of a written flit was not one-hot.

Function
REQ-016 SHALL write flit_in into the FIFO of its VC when flit_in_wr=1 and the VC field is one-hot.
REQ-017 SHALL drop the flit and set vc_err when flit_in_wr=1 and the VC field is zero or has more than one bit set.
REQ-018 SHALL drop the flit and set ovf_err when the target FIFO holds B flits and is not popped in the same cycle.
REQ-019 SHALL accept the write when the target FIFO is full and is popped in the same cycle; the count stays at B.
REQ-020 SHALL present a flit written in cycle N on the output no earlier than cycle N+1; there is no combinational path from flit_in to the out_* ports.
REQ-021 SHALL drive out_* from the head of the selected VC's FIFO; out_valid=1 iff that FIFO is non-empty.
REQ-022 SHALL pop the selected FIFO in any cycle where out_valid and out_ready are both 1.
REQ-023 SHALL hold out_payload, out_hdr, out_tail and out_vc stable while out_valid=1 and out_ready=0.
REQ-024 SHALL pulse credit_out[v] high for exactly one cycle in the cycle after each pop from VC v; one pulse per popped flit.
REQ-025 SHALL select the VC with a two-state FSM:
- IDLE: select by round-robin over non-empty VCs whose head flit has hdr=1, starting after the last granted VC.
- On a pop of a flit with hdr=1 and tail=0, go to LOCKED on that VC.
- LOCKED: select only the locked VC; return to IDLE on the pop of a flit with tail=1.
REQ-026 SHALL treat a flit with hdr=1 and tail=1 as a complete packet and stay in IDLE after popping it.
REQ-027 SHALL, in IDLE, present no flit (out_valid=0) while no VC has a header flit at its head.
REQ-028 SHALL handle a write and a pop on the same VC in the same cycle, updating the count by net zero.
REQ-029 SHALL compute the round-robin pointer modulo V; after VC V-1 the search wraps to VC 0.

Reset
REQ-030 SHALL, while reset=1, asynchronously clear all FIFO counts and pointers, set the FSM to IDLE, set the round-robin pointer to VC 0, and clear credit_out, ovf_err and vc_err.
REQ-031 SHALL hold out_valid=0 during reset; out_payload, out_hdr, out_tail and out_vc SHALL read 0 during reset.
REQ-032 SHALL discard buffered flits and issue no credit pulses when reset is asserted mid-packet.

Structure
REQ-033 SHALL take the flit field positions (header, tail, VC, payload) and Fw from the shared NoC parameter package.
REQ-034 SHALL instantiate sub-module ni_vc_fifo, one per VC; each instance is a B-deep FIFO of Fw-bit entries with push, pop, full, empty and head outputs.

Verification
REQ-035 SHALL cover: V=2; one single-flit packet (hdr=1, tail=1) on VC1 with payload 0xA5, out_ready=1 -> out_valid at cycle+1 with out_vc=2'b10, then credit_out=2'b10 for one cycle.
REQ-036 SHALL cover: interleaved writes of a 3-flit packet on VC0 and a 3-flit packet on VC1 -> output emits all VC0 flits, then all VC1 flits, with no interleaving.
REQ-037 SHALL cover: B+1 writes to VC0 with out_ready=0 -> ovf_err=1 and exactly B flits are delivered afterwards.
REQ-038 SHALL cover: a write with VC field 2'b11 -> vc_err=1, no flit is delivered, no credit is issued.
REQ-039 SHALL cover: VC0 full, with a write and a pop on VC0 in the same cycle -> no ovf_err, the count stays at B, and one credit pulse is issued.
REQ-040 SHALL cover: reset asserted after the header of a packet has been popped -> FSM in IDLE, out_valid=0, all credit_out=0.
